uart_cmd_assembler: RTL and testbench

- Sits directly downstream of the UART receiver. Consumes its byte-ready/byte-data pair and acknowledges each byte with a one-cycle clear pulse.
- Assembles two consecutive bytes, high byte first, into a 16-bit command word. Presents the word to the command processor with a ready/clear handshake.
- An inter-byte timeout discards a stranded high byte so the stream resynchronises.

---
 rtl/uart_cmd_assembler.sv | 112 +++++++++++
 tb/tb_uart_cmd_assembler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: pairs consecutive UART bytes (high first) into a 16-bit
// command word, with a ready/clear handshake toward the command processor and
// an inter-byte timeout that drops a stranded high byte.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        timeout_err,
  output logic        overrun
);

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  // Terminal timer value; the timeout fires here, so the timer never wraps.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_q, state_d;
  logic [7:0]      hi_byte_q, hi_byte_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            timeout_err_q, timeout_err_d;
  logic            overrun_q, overrun_d;
  logic            accept;

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_HI;
      hi_byte_q     <= '0;
      timer_q       <= '0;
      cmd_q         <= '0;
      cmd_rdy_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_byte_q     <= hi_byte_d;
      timer_q       <= timer_d;
      cmd_q         <= cmd_d;
      cmd_rdy_q     <= cmd_rdy_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  // Next-state, byte accept, command assembly and handshake flags.
  always_comb begin
    state_d       = state_q;
    hi_byte_d     = hi_byte_q;
    timer_d       = timer_q;
    cmd_d         = cmd_q;
    cmd_rdy_d     = cmd_rdy_q;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;
    accept        = 1'b0;

    // Consumer clear; a completion below in the same cycle overrides it.
    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end

    case (state_q)
      WAIT_HI: begin
        timer_d = '0;
        if (rx_rdy) begin
          accept    = 1'b1;
          hi_byte_d = rx_data;
          state_d   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        timer_d = timer_q + TO_W'(1);
        // A byte in the terminal-count cycle takes priority over the timeout.
        if (rx_rdy) begin
          accept    = 1'b1;
          cmd_d     = {hi_byte_q, rx_data};
          cmd_rdy_d = 1'b1;
          overrun_d = cmd_rdy_q & ~clr_cmd_rdy;
          timer_d   = '0;
          state_d   = WAIT_HI;
        end else if (timer_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          timer_d       = '0;
          state_d       = WAIT_HI;
        end
      end
      default: begin
        state_d = WAIT_HI;
      end
    endcase
  end

  // Receiver acknowledge is Mealy; held low while reset is asserted.
  assign clr_rx_rdy  = accept & ~rst;
  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: a vector table for the basic
// handshake/overrun cases plus directed sequences for timeout, boundary,
// reset and back-to-back delivery.
module tb_uart_cmd_assembler;

  logic        clk;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        timeout_err;
  logic        overrun;

  int unsigned n_cmp;
  int unsigned n_bad;

  uart_cmd_assembler #(
    .TIMEOUT_CYC(16),
    .TO_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .timeout_err(timeout_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [7:0]  data;
    logic        clr;
    logic        e_clr_rx;
    logic [15:0] e_cmd;
    logic        e_rdy;
    logic        e_to;
    logic        e_ov;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs at the negedge, check the Mealy ack, then check
  // the registered outputs at the following negedge.
  task automatic step(input string name, input logic r, input logic [7:0] d,
                      input logic c, input logic e_clr_rx, input logic [15:0] e_cmd,
                      input logic e_rdy, input logic e_to, input logic e_ov);
    rx_rdy      = r;
    rx_data     = d;
    clr_cmd_rdy = c;
    #1;
    chk({name, ".clr_rx_rdy"}, 32'(clr_rx_rdy), 32'(e_clr_rx));
    @(negedge clk);
    chk({name, ".cmd"}, 32'(cmd), 32'(e_cmd));
    chk({name, ".cmd_rdy"}, 32'(cmd_rdy), 32'(e_rdy));
    chk({name, ".timeout_err"}, 32'(timeout_err), 32'(e_to));
    chk({name, ".overrun"}, 32'(overrun), 32'(e_ov));
  endtask

  // Assert reset for two clocks and check that outputs clear immediately.
  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    chk({name, ".cmd"}, 32'(cmd), 32'h0);
    chk({name, ".cmd_rdy"}, 32'(cmd_rdy), 32'h0);
    chk({name, ".timeout_err"}, 32'(timeout_err), 32'h0);
    chk({name, ".overrun"}, 32'(overrun), 32'h0);
    chk({name, ".clr_rx_rdy"}, 32'(clr_rx_rdy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  b2b[4];
    logic [15:0] got_cmd[2];
    int unsigned n_got;
    int unsigned n_ack;
    int unsigned idx;
    logic        acked;
    logic [15:0] last_cmd;

    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;

    //           rdy  data   clr  ack   cmd       rdy  to   ov
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 16'hA53C, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hA53C, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hA53C, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hA53C, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h11, 1'b0, 1'b1, 16'hA53C, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h22, 1'b0, 1'b1, 16'h1122, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h33, 1'b0, 1'b1, 16'h1122, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 16'h3344, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h3344, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h55, 1'b0, 1'b1, 16'h3344, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h66, 1'b1, 1'b1, 16'h5566, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h5566, 1'b0, 1'b0, 1'b0};

    // Reset state.
    #2;
    chk("reset.cmd", 32'(cmd), 32'h0);
    chk("reset.cmd_rdy", 32'(cmd_rdy), 32'h0);
    chk("reset.timeout_err", 32'(timeout_err), 32'h0);
    chk("reset.overrun", 32'(overrun), 32'h0);
    chk("reset.clr_rx_rdy", 32'(clr_rx_rdy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table: normal command, clear handshake, overrun and set-wins clear.
    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].data, vecs[i].clr,
           vecs[i].e_clr_rx, vecs[i].e_cmd, vecs[i].e_rdy, vecs[i].e_to, vecs[i].e_ov);
    end

    // Timeout: high byte then silence; pulse exactly 16 clocks after accept.
    do_reset("rst_to");
    step("to_hi", 1'b1, 8'h12, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 18; n++) begin
      step($sformatf("to_wait%0d", n), 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0,
           (n == 16), 1'b0);
    end
    step("to_b34", 1'b1, 8'h34, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("to_b56", 1'b1, 8'h56, 1'b0, 1'b1, 16'h3456, 1'b1, 1'b0, 1'b0);
    step("to_clr", 1'b0, 8'h00, 1'b1, 1'b0, 16'h3456, 1'b0, 1'b0, 1'b0);

    // Boundary: low byte lands in the terminal-count cycle.
    step("bd_hi", 1'b1, 8'h77, 1'b0, 1'b1, 16'h3456, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 15; n++) begin
      step($sformatf("bd_wait%0d", n), 1'b0, 8'h00, 1'b0, 1'b0, 16'h3456, 1'b0,
           1'b0, 1'b0);
    end
    step("bd_lo", 1'b1, 8'h88, 1'b0, 1'b1, 16'h7788, 1'b1, 1'b0, 1'b0);
    step("bd_after1", 1'b0, 8'h00, 1'b0, 1'b0, 16'h7788, 1'b1, 1'b0, 1'b0);
    step("bd_after2", 1'b0, 8'h00, 1'b0, 1'b0, 16'h7788, 1'b1, 1'b0, 1'b0);

    // Reset while waiting for the low byte drops the partial command.
    step("mid_hi", 1'b1, 8'hFF, 1'b0, 1'b1, 16'h7788, 1'b1, 1'b0, 1'b0);
    rx_rdy = 1'b0;
    do_reset("rst_mid");
    step("mid_b01", 1'b1, 8'h01, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("mid_b02", 1'b1, 8'h02, 1'b0, 1'b1, 16'h0102, 1'b1, 1'b0, 1'b0);
    step("mid_clr", 1'b0, 8'h00, 1'b1, 1'b0, 16'h0102, 1'b0, 1'b0, 1'b0);

    // Back-to-back: receiver keeps rx_rdy high and advances on each ack.
    b2b[0]      = 8'hAB;
    b2b[1]      = 8'hCD;
    b2b[2]      = 8'hEF;
    b2b[3]      = 8'h01;
    got_cmd[0]  = 16'h0;
    got_cmd[1]  = 16'h0;
    n_got       = 0;
    n_ack       = 0;
    idx         = 0;
    last_cmd    = cmd;
    clr_cmd_rdy = 1'b0;
    rx_rdy      = 1'b1;
    rx_data     = b2b[0];
    for (int cyc = 0; cyc < 12 && idx < 4; cyc++) begin
      #1;
      acked = clr_rx_rdy;
      if (acked) n_ack++;
      @(posedge clk);
      #1;
      if (cmd_rdy && cmd != last_cmd) begin
        if (n_got < 2) got_cmd[n_got] = cmd;
        n_got++;
        last_cmd = cmd;
      end
      if (acked) begin
        idx++;
        if (idx < 4) rx_data = b2b[idx];
        else rx_rdy = 1'b0;
      end
      @(negedge clk);
    end
    rx_rdy = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      if (clr_rx_rdy) n_ack++;
      @(negedge clk);
    end
    chk("b2b.bytes_consumed", 32'(idx), 32'd4);
    chk("b2b.ack_pulses", 32'(n_ack), 32'd4);
    chk("b2b.cmd_count", 32'(n_got), 32'd2);
    chk("b2b.cmd0", 32'(got_cmd[0]), 32'hABCD);
    chk("b2b.cmd1", 32'(got_cmd[1]), 32'hEF01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
